// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared types and constants for the seven-segment scan controller:
//           scan state encoding and the active-low a..g hex font.
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Two-phase scan: all anodes off (BLANK), then one digit lit (DWELL).
    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_DWELL = 1'b1
    } scan_state_e;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}, indexed by nibble.
    localparam logic [15:0][6:0] C_FONT = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_controller_if
// Brief   : Valid/ready load port carrying display word, enable and DP masks.
// Revision: 1.0 - initial release
// ============================================================================
interface seg7_scan_controller_if;

    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_en;
    logic [7:0]  load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_en,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_en,
        input  load_dp,
        output load_ready
    );

endinterface
`default_nettype wire

// File: rtl/seg7_scan_controller_font_rom.sv
`default_nettype none
// ============================================================================
// Module  : seg7_font_rom
// Brief   : Combinational nibble to active-low a..g segment lookup.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_font_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Direct table lookup; the full 16-entry font covers every nibble value.
    assign segments = C_FONT[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_controller
// Brief   : Time-multiplexed 8-digit common-anode seven-segment scanner with
//           blanking gaps and a shadow/active double buffer that only swaps
//           at frame boundaries.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    seg7_scan_controller_if.slave   load_port,
    output logic [7:0]              out_cathode,
    output logic [7:0]              out_anode,
    output logic                    frame_done
);

    localparam int C_MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int C_CNT_W   = (C_MAX_CNT > 1) ? $clog2(C_MAX_CNT) : 1;
    localparam int C_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [C_CNT_W-1:0] C_DWELL_LAST = C_CNT_W'(DWELL - 1);
    localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] C_ST_BLANK = SCAN_BLANK;
    localparam logic [0:0] C_ST_DWELL = SCAN_DWELL;

    // Scan position of the current cycle
    logic [0:0]         r_state;
    logic [C_IDX_W-1:0] r_idx;
    logic [C_CNT_W-1:0] r_cnt;

    // Double-buffered display contents
    logic [31:0] r_act_data, r_sh_data;
    logic [7:0]  r_act_en,   r_sh_en;
    logic [7:0]  r_act_dp,   r_sh_dp;
    logic        r_pending;

    // Registered outputs
    logic [7:0]  r_anode;
    logic [7:0]  r_cathode;
    logic        r_frame_done;
    logic        r_load_ready;

    // Next-cycle scan position and the data it will display
    logic [0:0]         w_nxt_state;
    logic [C_IDX_W-1:0] w_nxt_idx;
    logic [C_CNT_W-1:0] w_nxt_cnt;
    logic               w_nxt_last;
    logic               w_accept;
    logic               w_xfer;
    logic [31:0]        w_act_data;
    logic [7:0]         w_act_en;
    logic [7:0]         w_act_dp;
    logic [2:0]         w_sel;
    logic [3:0]         w_nibble;
    logic               w_dig_en;
    logic               w_dig_dp;
    logic [6:0]         w_segments;
    logic [7:0]         w_nxt_anode;
    logic [7:0]         w_nxt_cathode;

    // r_frame_done is high exactly during the last DWELL cycle, so it doubles
    // as the "this cycle ends the frame" marker for the buffer swap.
    assign w_accept   = load_port.load_valid && !r_pending;
    assign w_xfer     = r_frame_done && r_pending;
    assign w_act_data = w_xfer ? r_sh_data : r_act_data;
    assign w_act_en   = w_xfer ? r_sh_en   : r_act_en;
    assign w_act_dp   = w_xfer ? r_sh_dp   : r_act_dp;
    assign w_sel      = 3'(w_nxt_idx);

    // Advance BLANK/DWELL phase, cycle counter and digit index
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt + C_CNT_W'(1);
        if (r_state == C_ST_BLANK) begin
            if (r_cnt == C_BLANK_LAST) begin
                w_nxt_state = C_ST_DWELL;
                w_nxt_cnt   = '0;
            end
        end else begin
            if (r_cnt == C_DWELL_LAST) begin
                w_nxt_state = C_ST_BLANK;
                w_nxt_cnt   = '0;
                w_nxt_idx   = (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IDX_W'(1);
            end
        end
    end

    assign w_nxt_last = (w_nxt_state == C_ST_DWELL) && (w_nxt_idx == C_IDX_LAST) &&
                        (w_nxt_cnt == C_DWELL_LAST);

    // Pick the nibble and mask bits of the digit about to be scanned
    always_comb begin
        w_nibble = '0;
        w_dig_en = 1'b0;
        w_dig_dp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w_sel == 3'(i)) begin
                w_nibble = w_act_data[31-4*i -: 4];
                w_dig_en = w_act_en[7-i];
                w_dig_dp = w_act_dp[7-i];
            end
        end
    end

    seg7_font_rom u_font_rom (
        .nibble   (w_nibble),
        .segments (w_segments)
    );

    // Build the pin patterns for the next cycle; disabled slots stay dark
    always_comb begin
        w_nxt_anode   = 8'hFF;
        w_nxt_cathode = w_dig_en ? {w_segments, ~w_dig_dp} : 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if ((w_sel == 3'(i)) && (w_nxt_state == C_ST_DWELL) && w_dig_en) begin
                w_nxt_anode[7-i] = 1'b0;
            end
        end
    end

    // Scan sequencer and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= C_ST_BLANK;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_anode      <= 8'hFF;
            r_cathode    <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_cnt        <= w_nxt_cnt;
            r_anode      <= w_nxt_anode;
            r_cathode    <= w_nxt_cathode;
            r_frame_done <= w_nxt_last;
        end
    end

    // Shadow capture on handshake, shadow-to-active swap at frame end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_act_data   <= '0;
            r_act_en     <= '0;
            r_act_dp     <= '0;
            r_sh_data    <= '0;
            r_sh_en      <= '0;
            r_sh_dp      <= '0;
            r_pending    <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_act_data <= w_act_data;
            r_act_en   <= w_act_en;
            r_act_dp   <= w_act_dp;
            if (w_accept) begin
                r_sh_data    <= load_port.load_data;
                r_sh_en      <= load_port.load_en;
                r_sh_dp      <= load_port.load_dp;
                r_pending    <= 1'b1;
                r_load_ready <= 1'b0;
            end else if (w_xfer) begin
                r_pending    <= 1'b0;
                r_load_ready <= 1'b1;
            end
        end
    end

    assign out_anode            = r_anode;
    assign out_cathode          = r_cathode;
    assign frame_done           = r_frame_done;
    assign load_port.load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_controller
// Brief   : Self-checking bench for seg7_scan_controller (DWELL=4, BLANK=2,
//           48-cycle frame) against a frame-position reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_controller;

    localparam int C_DWELL = 4;
    localparam int C_BLANK = 2;
    localparam int C_SLOT  = C_DWELL + C_BLANK;
    localparam int C_FRAME = 8 * C_SLOT;

    logic       clk;
    logic       rst;
    logic [7:0] cathode;
    logic [7:0] anode;
    logic       fdone;

    seg7_scan_controller_if lif ();

    seg7_scan_controller #(
        .NUM_DIGITS (8),
        .DWELL      (C_DWELL),
        .BLANK      (C_BLANK)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .load_port   (lif),
        .out_cathode (cathode),
        .out_anode   (anode),
        .frame_done  (fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] tb_font [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: frame position counter plus active/shadow contents
    int          m_t = 0;
    logic [31:0] m_act_d = '0, m_sh_d = '0;
    logic [7:0]  m_act_en = '0, m_act_dp = '0, m_sh_en = '0, m_sh_dp = '0;
    bit          m_pend = 1'b0;

    // Compare every cycle mid-period, then step the model across the next edge
    always @(negedge clk) begin
        int         p;
        int         slot;
        logic       en;
        logic       dp;
        logic [3:0] nib;
        logic [7:0] ea;
        logic [7:0] ec;
        bit         acc;
        bit         xfer;
        p    = m_t % C_FRAME;
        slot = p / C_SLOT;
        en   = m_act_en[3'(7 - slot)];
        dp   = m_act_dp[3'(7 - slot)];
        nib  = 4'(m_act_d >> (28 - 4 * slot));
        ec   = en ? {tb_font[nib], ~dp} : 8'hFF;
        ea   = (en && (p % C_SLOT) >= C_BLANK) ? ~(8'h80 >> slot) : 8'hFF;
        check_eq("anode",      32'(anode),          32'(ea));
        check_eq("cathode",    32'(cathode),        32'(ec));
        check_eq("frame_done", 32'(fdone),          32'(p == C_FRAME - 1));
        check_eq("load_ready", 32'(lif.load_ready), 32'(!m_pend));
        if (rst) begin
            m_t = 0; m_pend = 1'b0;
            m_act_d = '0; m_act_en = '0; m_act_dp = '0;
            m_sh_d = '0; m_sh_en = '0; m_sh_dp = '0;
        end else begin
            acc  = lif.load_valid && !m_pend;
            xfer = (p == C_FRAME - 1) && m_pend;
            if (xfer) begin
                m_act_d = m_sh_d; m_act_en = m_sh_en; m_act_dp = m_sh_dp;
                m_pend  = 1'b0;
            end
            if (acc) begin
                m_sh_d = lif.load_data; m_sh_en = lif.load_en; m_sh_dp = lif.load_dp;
                m_pend = 1'b1;
            end
            m_t++;
        end
    end

    // Raise valid with a word and hold until accepted; valid stays high
    task automatic offer(input logic [31:0] d, input logic [7:0] e, input logic [7:0] dpm);
        int n;
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        lif.load_en    = e;
        lif.load_dp    = dpm;
        n = 0;
        forever begin
            @(negedge clk);
            if (lif.load_ready) break;
            n++;
            if (n > 4 * C_FRAME) begin
                check_eq("handshake_timeout", 32'(0), 32'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Advance until the current cycle sits at a given frame position
    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if ((m_t % C_FRAME) == pos) break;
            n++;
            if (n > 2 * C_FRAME) begin
                check_eq("position_timeout", 32'(0), 32'(1));
                break;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        lif.load_en    = '0;
        lif.load_dp    = '0;

        // Reset and two idle frames
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * C_FRAME) @(posedge clk);
        #1;

        // Plain hex word, all digits on
        offer(32'h01234567, 8'hFF, 8'h00);
        lif.load_valid = 1'b0;
        repeat (3 * C_FRAME) @(posedge clk);
        #1;

        // Enable / decimal-point masks
        offer(32'h25000009, 8'b10000001, 8'b00000001);
        lif.load_valid = 1'b0;
        repeat (3 * C_FRAME) @(posedge clk);
        #1;

        // Back-to-back words with valid held high
        offer(32'hDEADBEEF, 8'hFF, 8'hAA);
        offer(32'h89ABCDEF, 8'hF0, 8'h0F);
        lif.load_valid = 1'b0;
        repeat (3 * C_FRAME) @(posedge clk);
        #1;

        // Load accepted on the frame_done cycle itself
        wait_pos(C_FRAME - 1);
        offer(32'h76543210, 8'hFF, 8'h81);
        lif.load_valid = 1'b0;
        repeat (3 * C_FRAME) @(posedge clk);
        #1;

        // Reset during DWELL(3) with a word pending
        wait_pos(0);
        offer(32'hCAFEF00D, 8'hFF, 8'hFF);
        lif.load_valid = 1'b0;
        wait_pos(3 * C_SLOT + C_BLANK);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * C_FRAME) @(posedge clk);
        #1;

        // Randomized traffic with sparse resets
        repeat (12 * C_FRAME) begin
            lif.load_valid = ($urandom_range(0, 7) == 0);
            lif.load_data  = $urandom;
            lif.load_en    = 8'($urandom);
            lif.load_dp    = 8'($urandom);
            rst            = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        rst            = 1'b0;
        lif.load_valid = 1'b0;
        repeat (2 * C_FRAME) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
